// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the data-memory responder and its link monitor.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int WAIT_CNT_BITS = 4;
  localparam int BYTE_LANES    = 4;

endpackage : cpu_mem_pkg

// File: rtl/dmem_link_monitor.sv
// Load-link/store-conditional reservation: holds the linked word address and
// decides SC success at commit time.
module dmem_link_monitor #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            commit,
  input  logic            is_ll,
  input  logic            is_sc,
  input  logic            is_wr,
  input  logic [BITS-1:0] addr,
  input  logic            any_be,
  output logic            sc_ok
);

  logic [BITS-1:0] r_link_addr;
  logic            r_link_valid;
  logic            w_match;

  assign w_match = r_link_valid && (r_link_addr == addr);
  assign sc_ok   = is_sc && w_match;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_link_addr  <= '0;
      r_link_valid <= 1'b0;
    end else if (commit) begin
      if (is_ll) begin
        r_link_addr  <= addr;
        r_link_valid <= 1'b1;
      end else if (is_sc) begin
        r_link_valid <= 1'b0;
      end else if (is_wr && any_be && w_match) begin
        // A plain store to the linked word breaks the reservation.
        r_link_valid <= 1'b0;
      end
    end
  end

endmodule : dmem_link_monitor

// File: rtl/dmem_responder.sv
// Handshaked data-memory slave with programmable wait states, byte-enabled
// writes and LL/SC. Optional address range check: DMEM_RANGE_CHECK_EN.
module dmem_responder
  import cpu_mem_pkg::*;
#(
  parameter int              BITS        = 32,
  parameter int              WORDS       = 256,
  parameter logic [BITS-1:0] BASE_ADDR   = 'h0000_2000,
  parameter int              WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rw_,
  input  logic                  req_ll,
  input  logic                  req_sc,
  input  logic [BITS-1:0]       req_addr,
  input  logic [BITS-1:0]       req_wdata,
  input  logic [BYTE_LANES-1:0] req_byte_en,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [BITS-1:0]       resp_rdata,
  output logic                  resp_sc_ok
`ifdef DMEM_RANGE_CHECK_EN
  ,
  output logic                  resp_err
`endif
);

  localparam int IDX_W  = $clog2(WORDS);
  localparam int LANE_W = BITS / BYTE_LANES;

  dmem_state_t r_state, w_next;

  logic [WAIT_CNT_BITS-1:0] r_cnt;
  logic                     r_rw_, r_ll, r_sc;
  logic [BITS-1:0]          r_addr, r_wdata;
  logic [BYTE_LANES-1:0]    r_be;
  logic [BITS-1:0]          r_rdata;
  logic                     r_sc_ok;
  logic [BITS-1:0]          r_mem [WORDS];

  logic                  w_accept, w_commit, w_from_req;
  logic                  w_rw_, w_ll, w_sc;
  logic [BITS-1:0]       w_addr, w_wdata;
  logic [BYTE_LANES-1:0] w_be;
  logic                  w_is_rd, w_is_wr, w_is_ll, w_is_sc, w_any_be;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_in_range, w_sc_ok, w_mem_we;

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_rdata = r_rdata;
  assign resp_sc_ok = r_sc_ok;
  assign w_accept   = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge, so the
  // operation is taken straight from the request port instead of the capture.
  assign w_from_req = (r_state == IDLE);
  assign w_rw_      = w_from_req ? req_rw_     : r_rw_;
  assign w_ll       = w_from_req ? req_ll      : r_ll;
  assign w_sc       = w_from_req ? req_sc      : r_sc;
  assign w_addr     = w_from_req ? req_addr    : r_addr;
  assign w_wdata    = w_from_req ? req_wdata   : r_wdata;
  assign w_be       = w_from_req ? req_byte_en : r_be;

  assign w_commit = (w_accept && (WAIT_CYCLES == 0)) ||
                    ((r_state == WAIT) && (r_cnt == '0));

  // LL together with SC degrades to an LL read.
  assign w_is_rd  = w_rw_ || (w_ll && w_sc);
  assign w_is_wr  = !w_is_rd;
  assign w_is_ll  = w_ll && w_is_rd;
  assign w_is_sc  = w_sc && w_is_wr;
  assign w_any_be = |w_be;
  assign w_idx    = IDX_W'(w_addr - BASE_ADDR);

`ifdef DMEM_RANGE_CHECK_EN
  logic [BITS-1:0] w_off;
  logic            r_err;
  assign w_off      = w_addr - BASE_ADDR;
  assign w_in_range = (w_off < BITS'(WORDS));
  assign resp_err   = r_err;
`else
  assign w_in_range = 1'b1;
`endif

  dmem_link_monitor #(.BITS(BITS)) u_link (
    .clk    (clk),
    .rst_   (rst_),
    .commit (w_commit && w_in_range),
    .is_ll  (w_is_ll),
    .is_sc  (w_is_sc),
    .is_wr  (w_is_wr),
    .addr   (w_addr),
    .any_be (w_any_be),
    .sc_ok  (w_sc_ok)
  );

  // A failed SC must not touch the array; reset also blocks a pending commit.
  assign w_mem_we = rst_ && w_commit && w_in_range && w_is_wr &&
                    (!w_is_sc || w_sc_ok);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: next state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (r_cnt == '0) w_next = RESP;
      RESP:    if (resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_cnt   <= '0;
      r_rw_   <= 1'b1;
      r_ll    <= 1'b0;
      r_sc    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
      r_sc_ok <= 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_rw_   <= req_rw_;
        r_ll    <= req_ll;
        r_sc    <= req_sc;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_byte_en;
        r_cnt   <= WAIT_CNT_BITS'(WAIT_CYCLES - 1);
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end

      if (w_commit) begin
`ifdef DMEM_RANGE_CHECK_EN
        r_err <= !w_in_range;
`endif
        if (!w_in_range) begin
          r_rdata <= '0;
          r_sc_ok <= 1'b0;
        end else if (w_is_rd) begin
          r_rdata <= r_mem[w_idx];
          r_sc_ok <= 1'b0;
        end else if (w_is_sc) begin
          r_rdata <= BITS'(w_sc_ok);
          r_sc_ok <= w_sc_ok;
        end else begin
          r_rdata <= '0;
          r_sc_ok <= 1'b0;
        end
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; its contents are
  // undefined until written.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        if (w_be[l]) r_mem[w_idx][l*LANE_W +: LANE_W] <= w_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2): latency,
// byte lanes, LL/SC reservation, response stall and mid-operation reset.
module tb_dmem_responder;

  localparam int WAIT_N = 2;

  logic        clk = 1'b0;
  logic        rst_;
  logic        req_valid, req_ready, req_rw_, req_ll, req_sc;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byte_en;
  logic        resp_valid, resp_ready, resp_sc_ok;
  logic [31:0] resp_rdata;
`ifdef DMEM_RANGE_CHECK_EN
  logic        resp_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_CYCLES(WAIT_N)) dut (
    .clk         (clk),
    .rst_        (rst_),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rw_     (req_rw_),
    .req_ll      (req_ll),
    .req_sc      (req_sc),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_byte_en (req_byte_en),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_rdata  (resp_rdata),
    .resp_sc_ok  (resp_sc_ok)
`ifdef DMEM_RANGE_CHECK_EN
    ,
    .resp_err    (resp_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transaction: drive at negedge, count cycles from the accept edge
  // to resp_valid, then complete the response handshake.
  task automatic xact(input string tag, input logic rw, input logic ll, input logic sc,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic [31:0] data, output logic ok);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_rw_ = rw; req_ll = ll; req_sc = sc;
    req_addr = addr; req_wdata = wdata; req_byte_en = be;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    check({tag, "_lat"}, n, WAIT_N + 1);
    data = resp_rdata;
    ok   = resp_sc_ok;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        ok;
    int          n;

    rst_ = 1'b0; req_valid = 1'b0; req_rw_ = 1'b1; req_ll = 1'b0; req_sc = 1'b0;
    req_addr = '0; req_wdata = '0; req_byte_en = '0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_rdata", resp_rdata, 0);
    check("rst_sc_ok", resp_sc_ok, 0);
    rst_ = 1'b1;

    // Full-word write and read-back, plus wrap-around alias.
    xact("wr_2005", 0, 0, 0, 32'h2005, 32'hDEADBEEF, 4'hF, d, ok);
    check("wr_2005_rdata", d, 0);
    xact("rd_2005", 1, 0, 0, 32'h2005, 0, 4'hF, d, ok);
    check("rd_2005_rdata", d, 32'hDEADBEEF);
    xact("rd_wrap", 1, 0, 0, 32'h2105, 0, 4'hF, d, ok);
    check("rd_wrap_rdata", d, 32'hDEADBEEF);
    xact("wr_be0", 0, 0, 0, 32'h2005, 32'h0, 4'h0, d, ok);
    xact("rd_be0", 1, 0, 0, 32'h2005, 0, 4'hF, d, ok);
    check("rd_be0_rdata", d, 32'hDEADBEEF);

    // Partial byte lanes.
    xact("wr_2010a", 0, 0, 0, 32'h2010, 32'h11223344, 4'hF, d, ok);
    xact("wr_2010b", 0, 0, 0, 32'h2010, 32'hAABBCCDD, 4'b0101, d, ok);
    xact("rd_2010", 1, 0, 0, 32'h2010, 0, 4'hF, d, ok);
    check("rd_2010_rdata", d, 32'h11BB33DD);

    // LL/SC success, then repeat SC fails.
    xact("ll_2020", 1, 1, 0, 32'h2020, 0, 4'hF, d, ok);
    xact("sc_2020", 0, 0, 1, 32'h2020, 32'd7, 4'hF, d, ok);
    check("sc_2020_ok", ok, 1);
    check("sc_2020_rdata", d, 1);
    xact("sc2_2020", 0, 0, 1, 32'h2020, 32'd8, 4'hF, d, ok);
    check("sc2_2020_ok", ok, 0);
    check("sc2_2020_rdata", d, 0);
    xact("rd_2020", 1, 0, 0, 32'h2020, 0, 4'hF, d, ok);
    check("rd_2020_rdata", d, 7);

    // Plain store breaks the link; SC to another address fails.
    xact("ll_2030", 1, 1, 0, 32'h2030, 0, 4'hF, d, ok);
    xact("wr_2030", 0, 0, 0, 32'h2030, 32'd5, 4'hF, d, ok);
    xact("sc_2030", 0, 0, 1, 32'h2030, 32'd9, 4'hF, d, ok);
    check("sc_2030_ok", ok, 0);
    xact("rd_2030", 1, 0, 0, 32'h2030, 0, 4'hF, d, ok);
    check("rd_2030_rdata", d, 5);
    xact("ll_2030b", 1, 1, 0, 32'h2030, 0, 4'hF, d, ok);
    xact("sc_2031", 0, 0, 1, 32'h2031, 32'd9, 4'hF, d, ok);
    check("sc_2031_ok", ok, 0);

    // A store with no byte lanes keeps the reservation.
    xact("ll_2060", 1, 1, 0, 32'h2060, 0, 4'hF, d, ok);
    xact("wr0_2060", 0, 0, 0, 32'h2060, 32'h1, 4'h0, d, ok);
    xact("sc_2060", 0, 0, 1, 32'h2060, 32'hA5, 4'hF, d, ok);
    check("sc_2060_ok", ok, 1);
    xact("rd_2060", 1, 0, 0, 32'h2060, 0, 4'hF, d, ok);
    check("rd_2060_rdata", d, 32'hA5);

    // LL+SC together behaves as an LL read.
    xact("wr_2070", 0, 0, 0, 32'h2070, 32'h55, 4'hF, d, ok);
    xact("llsc_2070", 0, 1, 1, 32'h2070, 32'h99, 4'hF, d, ok);
    check("llsc_2070_rdata", d, 32'h55);
    check("llsc_2070_ok", ok, 0);
    xact("sc_2070", 0, 0, 1, 32'h2070, 32'h66, 4'hF, d, ok);
    check("sc_2070_ok", ok, 1);
    xact("rd_2070", 1, 0, 0, 32'h2070, 0, 4'hF, d, ok);
    check("rd_2070_rdata", d, 32'h66);

    // Response stall with req_valid held high throughout.
    @(negedge clk);
    req_valid = 1'b1; req_rw_ = 1'b1; req_ll = 1'b0; req_sc = 1'b0;
    req_addr = 32'h2005; req_byte_en = 4'hF;
    @(negedge clk);
    n = 1;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    check("stall_lat", n, WAIT_N + 1);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", resp_valid, 1);
      check("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("hs_req_ready", req_ready, 1);
    check("hs_resp_valid", resp_valid, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("reaccept_req_ready", req_ready, 0);
    n = 0;
    while (!resp_valid && n < 50) begin @(negedge clk); n++; end
    check("reaccept_rdata", resp_rdata, 32'hDEADBEEF);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    @(negedge clk);
    check("single_accept", req_ready, 1);

    // Reset during the wait states of a write.
    xact("wr0_2040", 0, 0, 0, 32'h2040, 32'h0, 4'hF, d, ok);
    xact("ll_2040", 1, 1, 0, 32'h2040, 0, 4'hF, d, ok);
    @(negedge clk);
    req_valid = 1'b1; req_rw_ = 1'b0; req_ll = 1'b0; req_sc = 1'b0;
    req_addr = 32'h2040; req_wdata = 32'hCAFEF00D; req_byte_en = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    check("mid_wait_ready", req_ready, 0);
    rst_ = 1'b0;
    #1;
    check("mid_rst_req_ready", req_ready, 1);
    check("mid_rst_resp_valid", resp_valid, 0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;
    xact("rd_2040", 1, 0, 0, 32'h2040, 0, 4'hF, d, ok);
    check("rd_2040_rdata", d, 0);
    xact("sc_2040", 0, 0, 1, 32'h2040, 32'd3, 4'hF, d, ok);
    check("sc_2040_ok", ok, 0);
    check("sc_2040_rdata", d, 0);
    xact("rd2_2040", 1, 0, 0, 32'h2040, 0, 4'hF, d, ok);
    check("rd2_2040_rdata", d, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dmem_responder
